// File: rtl/seg7_scan2_if.sv
// Bundle between the BCD counter and the two-digit 7-segment driver.
// The display side (seg7_scan2) uses the slave modport.
interface seg7_scan2_if;
  logic [7:0] bcd_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  modport master (
    output bcd_in,
    input  seg,
    input  an,
    input  err
  );

  modport slave (
    input  bcd_in,
    output seg,
    output an,
    output err
  );
endinterface

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-segment driver with per-frame BCD snapshot.
// Optional leading-zero blanking of the tens digit: define SEG7_LZB_EN.
module seg7_scan2 #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  seg7_scan2_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } state_t;

  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  state_t           state_p0, state_nxt;
  logic [7:0]       snap_p0, snap_nxt;
  logic             tick;

  logic [6:0] seg_d, seg_p1;
  logic [1:0] an_d, an_p1;
  logic       err_d, err_p1;

  function automatic logic [6:0] dec(input logic [3:0] nib);
    case (nib)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction

  function automatic logic bad(input logic [3:0] nib);
    bad = (nib > 4'd9);
  endfunction

  // Stage p0: prescaler, digit state and frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0   <= '0;
      state_p0 <= DIG0;
      snap_p0  <= 8'h00;
    end else begin
      cnt_p0   <= cnt_nxt;
      state_p0 <= state_nxt;
      snap_p0  <= snap_nxt;
    end
  end

  // Snapshot only on the tens->ones wrap so a frame never mixes two inputs.
  always_comb begin
    tick      = (cnt_p0 == CNT_LAST);
    cnt_nxt   = cnt_p0 + CNT_W'(1);
    state_nxt = state_p0;
    snap_nxt  = snap_p0;
    if (tick) begin
      cnt_nxt   = '0;
      state_nxt = (state_p0 == DIG0) ? DIG1 : DIG0;
      if (state_p0 == DIG1) begin
        snap_nxt = bus.bcd_in;
      end
    end
  end

  always_comb begin
    err_d = bad(snap_p0[3:0]) | bad(snap_p0[7:4]);
    an_d  = 2'b01;
    seg_d = dec(snap_p0[3:0]);
    if (state_p0 == DIG1) begin
      an_d  = 2'b10;
      seg_d = dec(snap_p0[7:4]);
`ifdef SEG7_LZB_EN
      if (snap_p0[7:4] == 4'd0) begin
        an_d  = 2'b00;
        seg_d = 7'h00;
      end
`endif
    end
  end

  // Stage p1: registered display outputs, one cycle behind the scan state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_p1 <= 7'h00;
      an_p1  <= 2'b00;
      err_p1 <= 1'b0;
    end else begin
      seg_p1 <= seg_d;
      an_p1  <= an_d;
      err_p1 <= err_d;
    end
  end

  assign bus.seg = seg_p1;
  assign bus.an  = an_p1;
  assign bus.err = err_p1;

  an_never_both: assert property (@(posedge clk) disable iff (reset) bus.an != 2'b11);

endmodule

// File: tb/tb_seg7_scan2.sv
// Directed, table-driven bench for seg7_scan2 (SCAN_DIV=4 and SCAN_DIV=1 instances).
module tb_seg7_scan2;

  logic clk;
  logic rst4, rst1;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_scan2_if io4();
  seg7_scan2_if io1();

  seg7_scan2 #(.SCAN_DIV(4)) dut4 (.clk(clk), .reset(rst4), .bus(io4));
  seg7_scan2 #(.SCAN_DIV(1)) dut1 (.clk(clk), .reset(rst1), .bus(io1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] bcd;
    logic [1:0] an;
    logic [6:0] seg;
    logic       err;
    logic       tz;
  } vec_t;

  vec_t tbl [48];

  // Expected {err, an, seg}; a tens slot showing zero goes dark when blanking is built in.
  function automatic logic [9:0] expv(input logic err, input logic [1:0] an,
                                      input logic [6:0] seg, input logic tz);
    expv = {err, an, seg};
`ifdef SEG7_LZB_EN
    if (tz) expv = {err, 2'b00, 7'h00};
`endif
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got err/an/seg=%b/%b/%h expected %b/%b/%h",
               name, act[9], act[8:7], act[6:0], exp[9], exp[8:7], exp[6:0]);
    end
  endtask

  task automatic fill(input int lo, input int hi, input logic [1:0] an,
                      input logic [6:0] seg, input logic err, input logic tz);
    for (int e = lo; e <= hi; e++) begin
      tbl[e-1].an  = an;
      tbl[e-1].seg = seg;
      tbl[e-1].err = err;
      tbl[e-1].tz  = tz;
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;
    io4.bcd_in = 8'h00;
    io1.bcd_in = 8'h58;

    for (int i = 0; i < 48; i++) begin
      if (i + 1 <= 8)       tbl[i].bcd = 8'h47;
      else if (i + 1 <= 21) tbl[i].bcd = 8'h19;
      else if (i + 1 <= 24) tbl[i].bcd = 8'h20;
      else if (i + 1 <= 32) tbl[i].bcd = 8'h3A;
      else                  tbl[i].bcd = 8'h36;
    end
    fill( 1,  4, 2'b01, 7'h3F, 1'b0, 1'b0);
    fill( 5,  8, 2'b10, 7'h3F, 1'b0, 1'b1);
    fill( 9, 12, 2'b01, 7'h07, 1'b0, 1'b0);
    fill(13, 16, 2'b10, 7'h66, 1'b0, 1'b0);
    fill(17, 20, 2'b01, 7'h6F, 1'b0, 1'b0);
    fill(21, 24, 2'b10, 7'h06, 1'b0, 1'b0);
    fill(25, 28, 2'b01, 7'h3F, 1'b0, 1'b0);
    fill(29, 32, 2'b10, 7'h5B, 1'b0, 1'b0);
    fill(33, 36, 2'b01, 7'h40, 1'b1, 1'b0);
    fill(37, 40, 2'b10, 7'h4F, 1'b1, 1'b0);
    fill(41, 44, 2'b01, 7'h7D, 1'b0, 1'b0);
    fill(45, 48, 2'b10, 7'h4F, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("reset4", {io4.err, io4.an, io4.seg}, 10'b0);
    check("reset1", {io1.err, io1.an, io1.seg}, 10'b0);

    io4.bcd_in = tbl[0].bcd;
    rst4 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      io4.bcd_in = tbl[i].bcd;
      @(posedge clk);
      #1;
      check($sformatf("edge%0d", i + 1), {io4.err, io4.an, io4.seg},
            expv(tbl[i].err, tbl[i].an, tbl[i].seg, tbl[i].tz));
    end

    // Asynchronous reset in the middle of a tens slot
    io4.bcd_in = 8'h3A;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_dig1", {io4.err, io4.an, io4.seg}, expv(1'b1, 2'b10, 7'h4F, 1'b0));
    #2 rst4 = 1'b1;
    #1;
    check("async_rst", {io4.err, io4.an, io4.seg}, 10'b0);
    io4.bcd_in = 8'h00;
    @(posedge clk);
    #1;
    check("rst_held", {io4.err, io4.an, io4.seg}, 10'b0);
    rst4 = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_e1", {io4.err, io4.an, io4.seg}, expv(1'b0, 2'b01, 7'h3F, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_e5", {io4.err, io4.an, io4.seg}, expv(1'b0, 2'b10, 7'h3F, 1'b1));

    // SCAN_DIV=1: digits alternate every cycle
    rst1 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 1)
        check("div1_e1", {io1.err, io1.an, io1.seg}, expv(1'b0, 2'b01, 7'h3F, 1'b0));
      else if (e == 2)
        check("div1_e2", {io1.err, io1.an, io1.seg}, expv(1'b0, 2'b10, 7'h3F, 1'b1));
      else if (e % 2 == 1)
        check($sformatf("div1_e%0d", e), {io1.err, io1.an, io1.seg},
              expv(1'b0, 2'b01, 7'h7F, 1'b0));
      else
        check($sformatf("div1_e%0d", e), {io1.err, io1.an, io1.seg},
              expv(1'b0, 2'b10, 7'h6D, 1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
